spi_reg_commit_ctrl: RTL and testbench
======================================

Name: spi_reg_commit_ctrl

Overview:
- Register-bank controller between the SPI frame receiver and the PWM peripheral.
- Accepts validated 16-bit frames over a valid/ready handshake and decodes write address and data.
- Stages writes in shadow registers, then commits them atomically to the live PWM configuration outputs on a PWM period boundary, so the PWM never sees a partially updated configuration mid-period.
- Forces the commit after a timeout if no period boundary arrives.

Parameters:
- MAX_ADDR, 4: highest valid register address; writes above it are dropped.
- TIMEOUT_CYC, 1023: clk cycles a commit may stay pending before it is forced. Must be at least 1.
- TO_W, 10: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_valid  in  1  receiver holds a complete frame
- frame_data  in  16  [15]=R/W (1=write), [14:8]=address, [7:0]=data
- frame_ready  out  1  controller can accept a frame
- commit_tick  in  1  one-cycle pulse at PWM period boundary
- en_reg_out_7_0  out  8  live reg 0x00
- en_reg_out_15_8  out  8  live reg 0x01
- en_reg_pwm_7_0  out  8  live reg 0x02
- en_reg_pwm_15_8  out  8  live reg 0x03
- pwm_duty_cycle  out  8  live reg 0x04
- commit_pending  out  1  at least one shadow register is dirty
- commit_strobe  out  1  one-cycle pulse in the cycle the live registers update

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE.
  - All shadow and live registers clear to 0x00; dirty bits clear.
  - Timeout counter clears.
  - commit_pending=0, commit_strobe=0.
  - Staged writes in flight are discarded.
- FSM states: IDLE, DECODE, STAGE.
  - frame_ready=1 only in IDLE, and is decoded from the state register.
  - IDLE -> DECODE on frame_valid & frame_ready. frame_data is captured into a frame register at that edge.
  - DECODE: evaluates write = frame[15] and addr_ok = (frame[14:8] <= MAX_ADDR).
    - write & addr_ok -> STAGE.
    - Otherwise -> IDLE; the frame is dropped. Reads are a silent no-op.
  - STAGE: shadow[addr] <= data; dirty[addr] <= 1; -> IDLE.
  - Throughput is one frame per 3 cycles. A frame accepted at edge T is in shadow at edge T+2.
- Commit:
  - Commit condition: (commit_tick | timeout_hit) & (|dirty).
  - On the condition, each live[i] with dirty[i]=1 loads shadow[i] at the next edge; dirty clears; commit_strobe=1 for that one cycle.
  - Clean registers keep their live value.
  - commit_tick with no dirty bits set: no strobe, no change.
- Same-cycle STAGE and commit:
  - Commit uses the pre-edge shadow values.
  - The newly staged register's dirty bit ends set (set wins over clear). Its new value commits on the next condition.
- Timeout:
  - The counter runs only while |dirty and resets to 0 on every commit.
  - timeout_hit = (count == TIMEOUT_CYC).
  - Worst-case commit latency is TIMEOUT_CYC+1 cycles after the first dirty bit sets.
  - The counter saturates and never wraps.
- Rewriting a dirty register before commit overwrites the shadow; last write wins.
- commit_pending is the registered OR of the dirty bits.

Optional Feature:
- Macro: SPI_REG_ERR_STATS_EN.
- With the macro defined:
  - Adds output err_count (8 bits) and input err_clr (1 bit).
  - err_count increments, saturating at 0xFF, when DECODE sees write & !addr_ok.
  - err_clr=1 synchronously zeroes err_count; clear wins over a same-cycle increment.
  - err_count resets to 0.
- Without the macro: ports and logic are absent; invalid writes are dropped silently.

Decomposition:
- Shared package spi_pwm_pkg holds:
  - Address constants ADDR_EN_OUT_LO=0 through ADDR_DUTY=4.
  - Frame field offsets: RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8.
  - The FSM state enum.
  - MAX_ADDR default.
- One sub-module: spi_reg_shadow_slot, a single 8-bit shadow/live/dirty slot with stage and commit inputs. It is instantiated 5 times.
- The FSM and timeout logic stay in the top module.

Test Plan:
- Reset, then write frame 0x8455 (addr 4, data 0x55) with no tick:
  - pwm_duty_cycle stays 0x00 and commit_pending=1.
  - Pulse commit_tick: pwm_duty_cycle=0x55 one edge later, with a single commit_strobe.
- Write 0x80FF, then 0x8201; pulse one tick:
  - en_reg_out_7_0=0xFF and en_reg_pwm_7_0=0x01 update in the same cycle.
  - Other live registers unchanged.
- Write 0x8580 (addr 5) and 0x0410 (read), then tick:
  - No live change and no strobe.
  - With SPI_REG_ERR_STATS_EN, err_count=1.
- Write 0x8410 with no tick for TIMEOUT_CYC+1 cycles:
  - Forced commit sets pwm_duty_cycle=0x10.
  - commit_pending falls.
- Time commit_tick to coincide with STAGE of 0x8477, while reg 4 already dirty with 0x22:
  - Live reg 4 = 0x22 after this tick; commit_pending stays 1.
  - Next tick gives 0x77.
- Assert rst_n low during DECODE with reg 4 dirty:
  - All outputs 0 immediately.
  - frame_ready=1 after release; no later commit of the lost data.

Source files
------------

// File: rtl/spi_pwm_pkg.sv
// Shared definitions for the SPI register-bank / PWM commit controller:
// register addresses, frame field offsets and the controller FSM states.
package spi_pwm_pkg;

    // Live register addresses as seen in the SPI frame address field
    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;
    localparam int NUM_REGS       = ADDR_DUTY + 1;

    // Default highest writable address
    localparam int MAX_ADDR_DFLT  = 4;

    // Frame layout: [15]=R/W (1=write), [14:8]=address, [7:0]=data
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_STAGE  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_reg_commit_ctrl_if.sv
// Frame handshake between the SPI frame receiver (master) and the
// register commit controller (slave).
interface spi_reg_commit_ctrl_if;
    logic        frame_valid;
    logic [15:0] frame_data;
    logic        frame_ready;

    modport master (output frame_valid, output frame_data, input frame_ready);
    modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/spi_reg_shadow_slot.sv
// One 8-bit configuration slot: a shadow register written by the frame
// decoder, a live register seen by the PWM, and a dirty flag marking a
// staged value that has not yet been committed.
module spi_reg_shadow_slot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stage_en,
    input  logic [7:0] stage_data,
    input  logic       commit_en,
    output logic [7:0] live,
    output logic       dirty
);

    logic [7:0] shadow;

    // Stage into shadow; on commit copy shadow to live if this slot is dirty.
    // A same-cycle stage keeps the dirty flag set so the new value commits later.
    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // that is what lets a commit use the old shadow while a new stage lands.
    // NOTE: the shadow is a handful of flops, not a RAM, so it takes the reset
    // and in-flight staged data is discarded cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= 8'h00;
            live   <= 8'h00;
            dirty  <= 1'b0;
        end else begin
            if (stage_en)
                shadow <= stage_data;
            if (commit_en && dirty)
                live <= shadow;
            if (stage_en)
                dirty <= 1'b1;
            else if (commit_en)
                dirty <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_reg_commit_ctrl.sv
// Register-bank controller between the SPI frame receiver and the PWM.
// Frames are decoded into shadow registers and committed atomically to the
// live outputs on a PWM period tick, or forced after TIMEOUT_CYC cycles.
// Optional feature macro SPI_REG_ERR_STATS_EN adds err_clr / err_count,
// a saturating count of writes to out-of-range addresses.
module spi_reg_commit_ctrl
    import spi_pwm_pkg::*;
#(
    parameter int MAX_ADDR    = MAX_ADDR_DFLT,
    parameter int TIMEOUT_CYC = 1023,
    parameter int TO_W        = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_reg_commit_ctrl_if.slave    bus,
    input  logic                    commit_tick,
    output logic [7:0]              en_reg_out_7_0,
    output logic [7:0]              en_reg_out_15_8,
    output logic [7:0]              en_reg_pwm_7_0,
    output logic [7:0]              en_reg_pwm_15_8,
    output logic [7:0]              pwm_duty_cycle,
    output logic                    commit_pending,
    output logic                    commit_strobe
`ifdef SPI_REG_ERR_STATS_EN
    ,
    input  logic                    err_clr,
    output logic [7:0]              err_count
`endif
);

    state_t                       state, state_nxt;
    logic [15:0]                  frame_q;
    logic [6:0]                   frame_addr;
    logic                         is_write, addr_ok;
    logic [NUM_REGS-1:0]          stage_en, dirty, dirty_nxt;
    logic [NUM_REGS-1:0][7:0]     live;
    logic [TO_W-1:0]              to_count;
    logic                         timeout_hit, commit_go, accept;

    assign bus.frame_ready = (state == ST_IDLE);
    assign accept          = bus.frame_valid && (state == ST_IDLE);
    assign frame_addr      = frame_q[ADDR_MSB:ADDR_LSB];
    assign is_write        = frame_q[RW_BIT];
    assign addr_ok         = (int'(frame_addr) <= MAX_ADDR);
    assign timeout_hit     = (to_count == TO_W'(TIMEOUT_CYC));
    assign commit_go       = (commit_tick || timeout_hit) && (|dirty);

    // State register and frame capture at the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            frame_q <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (accept)
                frame_q <= bus.frame_data;
        end
    end

    // Next-state decode: reads and out-of-range writes fall back to IDLE.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = (is_write && addr_ok) ? ST_STAGE : ST_IDLE;
            ST_STAGE:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // One slot per live register; STAGE selects the slot by address.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
        assign stage_en[i]  = (state == ST_STAGE) && (frame_addr == 7'(i));
        assign dirty_nxt[i] = stage_en[i] || (dirty[i] && !commit_go);

        spi_reg_shadow_slot u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .stage_en   (stage_en[i]),
            .stage_data (frame_q[7:0]),
            .commit_en  (commit_go),
            .live       (live[i]),
            .dirty      (dirty[i])
        );
    end

    assign en_reg_out_7_0  = live[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = live[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = live[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = live[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = live[ADDR_DUTY];

    // Pending timeout counter: restarts on commit, runs while dirty, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_count <= '0;
        else if (commit_go)
            to_count <= '0;
        else if ((|dirty) && !timeout_hit)
            to_count <= to_count + TO_W'(1);
    end

    // Registered status: pending mirrors the dirty bits, strobe marks live update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pending <= 1'b0;
            commit_strobe  <= 1'b0;
        end else begin
            commit_pending <= |dirty_nxt;
            commit_strobe  <= commit_go;
        end
    end

`ifdef SPI_REG_ERR_STATS_EN
    // Saturating count of out-of-range writes; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= 8'h00;
        else if (err_clr)
            err_count <= 8'h00;
        else if ((state == ST_DECODE) && is_write && !addr_ok && (err_count != 8'hFF))
            err_count <= err_count + 8'h01;
    end
`endif

endmodule

// File: tb/tb_spi_reg_commit_ctrl.sv
// Directed self-checking bench for spi_reg_commit_ctrl (default parameters).
// Inputs change at negedge or 1ns after posedge; outputs sampled 1ns after posedge.
module tb_spi_reg_commit_ctrl;

    localparam int TIMEOUT_CYC = 1023;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       commit_tick = 1'b0;
    logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
    logic       commit_pending, commit_strobe;
`ifdef SPI_REG_ERR_STATS_EN
    logic       err_clr = 1'b0;
    logic [7:0] err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    spi_reg_commit_ctrl_if bus ();

    spi_reg_commit_ctrl #(.MAX_ADDR(4), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(10)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .commit_tick     (commit_tick),
        .en_reg_out_7_0  (out_lo),
        .en_reg_out_15_8 (out_hi),
        .en_reg_pwm_7_0  (pwm_lo),
        .en_reg_pwm_15_8 (pwm_hi),
        .pwm_duty_cycle  (duty),
        .commit_pending  (commit_pending),
        .commit_strobe   (commit_strobe)
`ifdef SPI_REG_ERR_STATS_EN
        ,
        .err_clr         (err_clr),
        .err_count       (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Present a frame once frame_ready is seen; returns 1ns after the accepting edge.
    task automatic send_frame(input logic [15:0] d);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_ready === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL send_frame_ready: frame_ready never seen for %h", d);
        end
        bus.frame_valid = 1'b1;
        bus.frame_data  = d;
        @(posedge clk);
        #1;
        bus.frame_valid = 1'b0;
    endtask

    // Full write: returns 1ns after the edge that writes the shadow.
    task automatic write_reg(input logic [15:0] d);
        send_frame(d);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One-cycle commit_tick; returns 1ns after the edge that sampled it.
    task automatic pulse_tick();
        @(negedge clk);
        commit_tick = 1'b1;
        @(posedge clk);
        #1;
        commit_tick = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.frame_valid = 1'b0;
        bus.frame_data  = 16'h0000;
        #12;
        n_checks++; if ({out_lo, out_hi, pwm_lo, pwm_hi, duty} !== 40'h0) begin n_fail++; $display("FAIL reset_live: got %h exp 0", {out_lo, out_hi, pwm_lo, pwm_hi, duty}); end
        n_checks++; if ({commit_pending, commit_strobe} !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b exp 00", {commit_pending, commit_strobe}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++; if (bus.frame_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", bus.frame_ready); end
`ifdef SPI_REG_ERR_STATS_EN
        n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err: got %h exp 00", err_count); end
`endif
    endtask

    task automatic test_single_write();
        write_reg(16'h8455);
        n_checks++; if (duty !== 8'h00) begin n_fail++; $display("FAIL single_no_tick_duty: got %h exp 00", duty); end
        n_checks++; if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL single_pending: got %b exp 1", commit_pending); end
        repeat (5) step();
        n_checks++; if (duty !== 8'h00 || commit_strobe !== 1'b0) begin n_fail++; $display("FAIL single_hold: got duty %h strobe %b exp 00 0", duty, commit_strobe); end
        pulse_tick();
        n_checks++; if (duty !== 8'h55) begin n_fail++; $display("FAIL single_commit_duty: got %h exp 55", duty); end
        n_checks++; if (commit_strobe !== 1'b1) begin n_fail++; $display("FAIL single_strobe: got %b exp 1", commit_strobe); end
        n_checks++; if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL single_pending_clr: got %b exp 0", commit_pending); end
        step();
        n_checks++; if (commit_strobe !== 1'b0) begin n_fail++; $display("FAIL single_strobe_once: got %b exp 0", commit_strobe); end
    endtask

    task automatic test_two_regs();
        write_reg(16'h80FF);
        write_reg(16'h8201);
        n_checks++; if (out_lo !== 8'h00 || pwm_lo !== 8'h00) begin n_fail++; $display("FAIL two_before: got %h %h exp 00 00", out_lo, pwm_lo); end
        pulse_tick();
        n_checks++; if (out_lo !== 8'hFF || pwm_lo !== 8'h01) begin n_fail++; $display("FAIL two_commit: got %h %h exp ff 01", out_lo, pwm_lo); end
        n_checks++; if (out_hi !== 8'h00 || pwm_hi !== 8'h00 || duty !== 8'h55) begin n_fail++; $display("FAIL two_others: got %h %h %h exp 00 00 55", out_hi, pwm_hi, duty); end
        n_checks++; if (commit_strobe !== 1'b1) begin n_fail++; $display("FAIL two_strobe: got %b exp 1", commit_strobe); end
    endtask

    task automatic test_invalid();
        write_reg(16'h8580);
        write_reg(16'h0410);
        n_checks++; if (commit_pending !== 1'b0) begin n_fail++; $display("FAIL invalid_pending: got %b exp 0", commit_pending); end
        pulse_tick();
        n_checks++; if (commit_strobe !== 1'b0) begin n_fail++; $display("FAIL invalid_strobe: got %b exp 0", commit_strobe); end
        n_checks++; if ({out_lo, out_hi, pwm_lo, pwm_hi, duty} !== 40'hFF_00_01_00_55) begin n_fail++; $display("FAIL invalid_live: got %h exp ff00010055", {out_lo, out_hi, pwm_lo, pwm_hi, duty}); end
`ifdef SPI_REG_ERR_STATS_EN
        n_checks++; if (err_count !== 8'h01) begin n_fail++; $display("FAIL invalid_err_count: got %h exp 01", err_count); end
        @(negedge clk);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL err_clr: got %h exp 00", err_count); end
`endif
    endtask

    task automatic test_back_to_back();
        send_frame(16'h8401);
        n_checks++; if (bus.frame_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_decode: got %b exp 0", bus.frame_ready); end
        step();
        n_checks++; if (bus.frame_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_stage: got %b exp 0", bus.frame_ready); end
        step();
        n_checks++; if (bus.frame_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle: got %b exp 1", bus.frame_ready); end
        write_reg(16'h8402);
        pulse_tick();
        n_checks++; if (duty !== 8'h02) begin n_fail++; $display("FAIL b2b_last_wins: got %h exp 02", duty); end
    endtask

    task automatic test_timeout();
        write_reg(16'h8410);
        repeat (TIMEOUT_CYC) step();
        n_checks++; if (duty !== 8'h02 || commit_pending !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got duty %h pend %b exp 02 1", duty, commit_pending); end
        step();
        n_checks++; if (duty !== 8'h10) begin n_fail++; $display("FAIL timeout_duty: got %h exp 10", duty); end
        n_checks++; if (commit_strobe !== 1'b1 || commit_pending !== 1'b0) begin n_fail++; $display("FAIL timeout_status: got strobe %b pend %b exp 1 0", commit_strobe, commit_pending); end
    endtask

    task automatic test_stage_commit_overlap();
        write_reg(16'h8422);
        send_frame(16'h8477);
        // Accepted edge T is behind us; tick lands on edge T+2 with the STAGE write.
        @(posedge clk);
        @(negedge clk);
        commit_tick = 1'b1;
        @(posedge clk);
        #1;
        commit_tick = 1'b0;
        n_checks++; if (duty !== 8'h22) begin n_fail++; $display("FAIL overlap_old_value: got %h exp 22", duty); end
        n_checks++; if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL overlap_pending: got %b exp 1", commit_pending); end
        pulse_tick();
        n_checks++; if (duty !== 8'h77 || commit_pending !== 1'b0) begin n_fail++; $display("FAIL overlap_next: got duty %h pend %b exp 77 0", duty, commit_pending); end
    endtask

    task automatic test_reset_in_decode();
        write_reg(16'h8433);
        send_frame(16'h8499);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({out_lo, out_hi, pwm_lo, pwm_hi, duty} !== 40'h0) begin n_fail++; $display("FAIL rst_decode_live: got %h exp 0", {out_lo, out_hi, pwm_lo, pwm_hi, duty}); end
        n_checks++; if ({commit_pending, commit_strobe} !== 2'b00) begin n_fail++; $display("FAIL rst_decode_status: got %b exp 00", {commit_pending, commit_strobe}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++; if (bus.frame_ready !== 1'b1) begin n_fail++; $display("FAIL rst_decode_ready: got %b exp 1", bus.frame_ready); end
        pulse_tick();
        n_checks++; if (commit_strobe !== 1'b0 || duty !== 8'h00) begin n_fail++; $display("FAIL rst_decode_no_commit: got strobe %b duty %h exp 0 00", commit_strobe, duty); end
        repeat (20) step();
        n_checks++; if (duty !== 8'h00 || commit_pending !== 1'b0) begin n_fail++; $display("FAIL rst_decode_quiet: got duty %h pend %b exp 00 0", duty, commit_pending); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_two_regs();
        test_invalid();
        test_back_to_back();
        test_timeout();
        test_stage_commit_overlap();
        test_reset_in_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
